// File: rtl/mmu_feed_scheduler.sv
// Sequencer for one 2x2 x 2x2 multiply on the systolic MMU: fetch operands, clear, skewed feed,
// settle, then drain the four results through a valid/ready port.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// S_IDLE   | waiting for start
// S_FETCH  | read 8 operands from weight memory (cnt 0..8)
// S_CLEAR  | one cycle of mmu_clear
// S_FEED   | three cycles of diagonally skewed operands into the array
// S_SETTLE | SETTLE_CYCLES cycles of zero input while partial sums propagate
// S_OUTPUT | present c00..c11 on out_sel, advance on each handshake
// S_DONE   | one-cycle done pulse
module mmu_feed_scheduler #(
   parameter int DATA_W        = 8,
   parameter int SETTLE_CYCLES = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   output logic              busy,
   output logic              done,
   output logic              mem_rd_en,
   output logic [2:0]        mem_addr,
   input  logic [DATA_W-1:0] mem_rd_data,
   output logic              mmu_clear,
   output logic              mmu_en,
   output logic [DATA_W-1:0] a_row0,
   output logic [DATA_W-1:0] a_row1,
   output logic [DATA_W-1:0] b_col0,
   output logic [DATA_W-1:0] b_col1,
   output logic [1:0]        out_sel,
   output logic              out_valid,
   input  logic              out_ready
);

   typedef enum logic [2:0] {
      S_IDLE, S_FETCH, S_CLEAR, S_FEED, S_SETTLE, S_OUTPUT, S_DONE
   } state_t;

   localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);

   state_t            state;
   logic [3:0]        cnt;
   logic [DATA_W-1:0] opnd [8];

   // Every output is computed for the state being entered, so it is valid in the same cycle as that state.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= S_IDLE;
         cnt       <= '0;
         busy      <= 1'b0;
         done      <= 1'b0;
         mem_rd_en <= 1'b0;
         mem_addr  <= '0;
         mmu_clear <= 1'b0;
         mmu_en    <= 1'b0;
         a_row0    <= '0;
         a_row1    <= '0;
         b_col0    <= '0;
         b_col1    <= '0;
         out_sel   <= '0;
         out_valid <= 1'b0;
         for (int i = 0; i < 8; i++) opnd[i] <= '0;
      end else begin
         done      <= 1'b0;
         mem_rd_en <= 1'b0;
         mem_addr  <= '0;
         mmu_clear <= 1'b0;
         mmu_en    <= 1'b0;
         a_row0    <= '0;
         a_row1    <= '0;
         b_col0    <= '0;
         b_col1    <= '0;
         out_sel   <= '0;
         out_valid <= 1'b0;
         case (state)
            S_IDLE: begin
               if (start) begin
                  state     <= S_FETCH;
                  cnt       <= '0;
                  busy      <= 1'b1;
                  mem_rd_en <= 1'b1;
               end
            end
            S_FETCH: begin
               // read data lags the strobe by one cycle
               if (cnt != 4'd0) opnd[3'(cnt - 4'd1)] <= mem_rd_data;
               if (cnt == 4'd8) begin
                  state     <= S_CLEAR;
                  cnt       <= '0;
                  mmu_clear <= 1'b1;
               end else begin
                  cnt <= cnt + 4'd1;
                  if (cnt < 4'd7) begin
                     mem_rd_en <= 1'b1;
                     mem_addr  <= 3'(cnt + 4'd1);
                  end
               end
            end
            S_CLEAR: begin
               state  <= S_FEED;
               cnt    <= '0;
               mmu_en <= 1'b1;
               a_row0 <= opnd[0];
               b_col0 <= opnd[4];
            end
            S_FEED: begin
               mmu_en <= 1'b1;
               case (cnt)
                  4'd0: begin
                     cnt    <= 4'd1;
                     a_row0 <= opnd[1];
                     a_row1 <= opnd[2];
                     b_col0 <= opnd[6];
                     b_col1 <= opnd[5];
                  end
                  4'd1: begin
                     cnt    <= 4'd2;
                     a_row1 <= opnd[3];
                     b_col1 <= opnd[7];
                  end
                  default: begin
                     state <= S_SETTLE;
                     cnt   <= '0;
                  end
               endcase
            end
            S_SETTLE: begin
               if (cnt == SETTLE_LAST) begin
                  state     <= S_OUTPUT;
                  cnt       <= '0;
                  out_valid <= 1'b1;
               end else begin
                  cnt    <= cnt + 4'd1;
                  mmu_en <= 1'b1;
               end
            end
            S_OUTPUT: begin
               if (out_valid && out_ready) begin
                  if (out_sel == 2'd3) begin
                     state <= S_DONE;
                     cnt   <= '0;
                     done  <= 1'b1;
                  end else begin
                     out_valid <= 1'b1;
                     out_sel   <= out_sel + 2'd1;
                  end
               end else begin
                  out_valid <= 1'b1;
                  out_sel   <= out_sel;
               end
            end
            S_DONE: begin
               state <= S_IDLE;
               cnt   <= '0;
               busy  <= 1'b0;
            end
            default: begin
               state <= S_IDLE;
               cnt   <= '0;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule
